// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types for the instruction fetch front end.
//   inst_t        - one 32-bit instruction word
//   fetch_entry_t - queue entry {pc, inst}
//   state_e       - fetch request FSM states
package fetch_pkg;
  localparam int INST_BYTES = 4;

  typedef logic [31:0] inst_t;

  typedef struct packed {
    logic [31:0] pc;
    inst_t       inst;
  } fetch_entry_t;

  typedef enum logic [1:0] {IDLE, WAIT, STALE} state_e;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry circular buffer of fetch entries.
//   clk, rst_n   - clock, async active-low reset
//   flush_i      - drop all entries (head jumps to tail), overrides enq/deq
//   enq_i        - write WIDTH entries from enq_data_i at the tail
//   deq_n_i      - retire 0..WIDTH entries from the head
//   count_o      - current occupancy
//   rd_data_o    - entries head+0 .. head+WIDTH-1 (unqualified)
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int PW = AW + 1,
  localparam int NW = $clog2(WIDTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     enq_i,
  input  fetch_entry_t [WIDTH-1:0] enq_data_i,
  input  logic [NW-1:0]            deq_n_i,
  output logic [PW-1:0]            count_o,
  output fetch_entry_t [WIDTH-1:0] rd_data_o
);
  logic [PW-1:0] head_q, tail_q, count_q;
  fetch_entry_t  mem_q [DEPTH];

  // Pointers carry a wrap bit; only the low AW bits address storage.
  logic unused_ptr_msbs;
  assign unused_ptr_msbs = head_q[AW] ^ tail_q[AW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      head_q  <= tail_q;
      count_q <= '0;
    end else begin
      head_q <= head_q + PW'(deq_n_i);
      if (enq_i) begin
        tail_q  <= tail_q + PW'(WIDTH);
        count_q <= count_q + PW'(WIDTH) - PW'(deq_n_i);
      end else begin
        count_q <= count_q - PW'(deq_n_i);
      end
    end
  end

  // Storage needs no reset: nothing is read as valid until count covers it.
  always_ff @(posedge clk) begin
    if (enq_i && !flush_i) begin
      for (int k = 0; k < WIDTH; k++) begin
        mem_q[tail_q[AW-1:0] + AW'(k)] <= enq_data_i[k];
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_rd
    assign rd_data_o[i] = mem_q[head_q[AW-1:0] + AW'(i)];
  end

  assign count_o = count_q;
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: N-wide fetch front end. Owns the fetch PC, issues one
// WIDTH-word request at a time to instruction memory, buffers responses
// in fetch_fifo and presents the oldest WIDTH entries to decode.
//   clk, reset        - clock, async active-low reset
//   redirect_valid/pc - flush queue, refetch from redirect_pc
//   can_proceed       - per-lane decode accept (leading-ones prefix used)
//   imem_req_*        - request handshake, addr = fetch PC
//   imem_resp_*       - in-order response, word k = instruction at addr+4k
//   inst_valid/inst/pc- decode lanes, lane i = queue head + i
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          WIDTH    = 2,
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  input  logic [WIDTH-1:0]      can_proceed,
  output logic                  imem_req_valid,
  output logic [31:0]           imem_req_addr,
  input  logic                  imem_req_ready,
  input  logic                  imem_resp_valid,
  input  logic [WIDTH*32-1:0]   imem_resp_data,
  output logic [WIDTH-1:0]      inst_valid,
  output logic [WIDTH-1:0][31:0] inst,
  output logic [WIDTH-1:0][31:0] pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int NW = $clog2(WIDTH + 1);

  state_e        state_q;
  logic [31:0]   fetch_pc_q;
  logic [PW-1:0] count;
  logic [NW-1:0] deq_n;
  logic          enq, space_ok, run;
  fetch_entry_t [WIDTH-1:0] enq_data, rd_data;

  logic [31:0] redir_pc_al;
  logic        unused_redir_lsbs;
  assign redir_pc_al       = {redirect_pc[31:2], 2'b00};
  assign unused_redir_lsbs = ^redirect_pc[1:0];

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    assign inst_valid[i]    = count > PW'(i);
    assign inst[i]          = rd_data[i].inst;
    assign pc[i]            = rd_data[i].pc;
    assign enq_data[i].pc   = fetch_pc_q + 32'(INST_BYTES * i);
    assign enq_data[i].inst = imem_resp_data[32*i +: 32];
  end

  // Retire the leading run of accepted+valid lanes; a gap ends the run.
  always_comb begin
    deq_n = '0;
    run   = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (run && can_proceed[i] && inst_valid[i]) deq_n = deq_n + NW'(1);
      else run = 1'b0;
    end
    if (redirect_valid) deq_n = '0;
  end

  // Room is checked against the current count only; with a single
  // outstanding request, dequeues can only add room before the response.
  assign space_ok       = (PW'(DEPTH) - count) >= PW'(WIDTH);
  assign imem_req_valid = reset && (state_q == IDLE) && space_ok && !redirect_valid;
  assign imem_req_addr  = fetch_pc_q;
  assign enq            = (state_q == WAIT) && imem_resp_valid && !redirect_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
    end else begin
      if (redirect_valid)  fetch_pc_q <= redir_pc_al;
      else if (enq)        fetch_pc_q <= fetch_pc_q + 32'(INST_BYTES * WIDTH);
      unique case (state_q)
        IDLE:    if (imem_req_valid && imem_req_ready) state_q <= WAIT;
        // A response always closes the outstanding request, even if a
        // redirect in the same cycle discards its data.
        WAIT:    if (imem_resp_valid)     state_q <= IDLE;
                 else if (redirect_valid) state_q <= STALE;
        STALE:   if (imem_resp_valid)     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  fetch_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .flush_i    (redirect_valid),
    .enq_i      (enq),
    .enq_data_i (enq_data),
    .deq_n_i    (deq_n),
    .count_o    (count),
    .rd_data_o  (rd_data)
  );
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks on a WIDTH=2/DEPTH=8 instance plus a
// randomized scoreboard run on a WIDTH=4/DEPTH=16 instance.
module tb_fetch_queue;
  import fetch_pkg::*;
  localparam int WA = 2, DA = 8, WB = 4, DB = 16;
  localparam logic [31:0] RPC_B = 32'hFFFF_FFE0;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  function automatic logic [31:0] mk(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  // ---------------- DUT A ----------------
  logic redir_a; logic [31:0] rpc_a; logic [WA-1:0] cp_a;
  logic rq_v_a, rq_rdy_a, rs_v_a; logic [31:0] rq_addr_a;
  logic [WA*32-1:0] rs_d_a;
  logic [WA-1:0] iv_a; logic [WA-1:0][31:0] inst_a, pc_a;
  int lat_a = 1;

  fetch_queue #(.WIDTH(WA), .DEPTH(DA), .RESET_PC(32'h0)) dut_a (
    .clk(clk), .reset(reset), .redirect_valid(redir_a), .redirect_pc(rpc_a),
    .can_proceed(cp_a), .imem_req_valid(rq_v_a), .imem_req_addr(rq_addr_a),
    .imem_req_ready(rq_rdy_a), .imem_resp_valid(rs_v_a), .imem_resp_data(rs_d_a),
    .inst_valid(iv_a), .inst(inst_a), .pc(pc_a));

  // ---------------- DUT B ----------------
  logic redir_b; logic [31:0] rpc_b; logic [WB-1:0] cp_b;
  logic rq_v_b, rq_rdy_b, rs_v_b; logic [31:0] rq_addr_b;
  logic [WB*32-1:0] rs_d_b;
  logic [WB-1:0] iv_b; logic [WB-1:0][31:0] inst_b, pc_b;
  int lat_b = 1;

  fetch_queue #(.WIDTH(WB), .DEPTH(DB), .RESET_PC(RPC_B)) dut_b (
    .clk(clk), .reset(reset), .redirect_valid(redir_b), .redirect_pc(rpc_b),
    .can_proceed(cp_b), .imem_req_valid(rq_v_b), .imem_req_addr(rq_addr_b),
    .imem_req_ready(rq_rdy_b), .imem_resp_valid(rs_v_b), .imem_resp_data(rs_d_b),
    .inst_valid(iv_b), .inst(inst_b), .pc(pc_b));

  // Memory models: response valid in the cycle ending lat edges after the
  // handshake edge (lat=1 means the cycle right after the handshake).
  logic pend_a; int cnt_a; logic [31:0] maddr_a;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_a <= 1'b0; cnt_a <= 0; rs_v_a <= 1'b0; rs_d_a <= '0; maddr_a <= '0;
    end else begin
      rs_v_a <= 1'b0;
      if (pend_a) begin
        if (cnt_a <= 1) begin
          rs_v_a <= 1'b1; pend_a <= 1'b0;
          for (int k = 0; k < WA; k++) rs_d_a[32*k +: 32] <= mk(maddr_a + 32'(4*k));
        end else cnt_a <= cnt_a - 1;
      end else if (rq_v_a && rq_rdy_a) begin
        if (lat_a <= 1) begin
          rs_v_a <= 1'b1;
          for (int k = 0; k < WA; k++) rs_d_a[32*k +: 32] <= mk(rq_addr_a + 32'(4*k));
        end else begin
          pend_a <= 1'b1; cnt_a <= lat_a - 1; maddr_a <= rq_addr_a;
        end
      end
    end
  end

  logic pend_b; int cnt_b; logic [31:0] maddr_b;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_b <= 1'b0; cnt_b <= 0; rs_v_b <= 1'b0; rs_d_b <= '0; maddr_b <= '0;
    end else begin
      rs_v_b <= 1'b0;
      if (pend_b) begin
        if (cnt_b <= 1) begin
          rs_v_b <= 1'b1; pend_b <= 1'b0;
          for (int k = 0; k < WB; k++) rs_d_b[32*k +: 32] <= mk(maddr_b + 32'(4*k));
        end else cnt_b <= cnt_b - 1;
      end else if (rq_v_b && rq_rdy_b) begin
        if (lat_b <= 1) begin
          rs_v_b <= 1'b1;
          for (int k = 0; k < WB; k++) rs_d_b[32*k +: 32] <= mk(rq_addr_b + 32'(4*k));
        end else begin
          pend_b <= 1'b1; cnt_b <= lat_b - 1; maddr_b <= rq_addr_b;
        end
      end
    end
  end

  // A response must never arrive while the front end is idle.
  always @(negedge clk) begin
    if (reset && rs_v_a) assert (dut_a.state_q != IDLE) else $error("resp while IDLE (A)");
    if (reset && rs_v_b) assert (dut_b.state_q != IDLE) else $error("resp while IDLE (B)");
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Leaves the bench 1ns after an edge with reset just released: cycle 0.
  task automatic do_reset();
    reset = 1'b0;
    redir_a = 1'b0; rpc_a = '0; cp_a = '0; rq_rdy_a = 1'b1; lat_a = 1;
    redir_b = 1'b0; rpc_b = '0; cp_b = '0; rq_rdy_b = 1'b0; lat_b = 1;
    step(); step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    redir_a = 1'b0; rpc_a = '0; cp_a = '1; rq_rdy_a = 1'b1; lat_a = 1;
    redir_b = 1'b0; rpc_b = '0; cp_b = '1; rq_rdy_b = 1'b0; lat_b = 1;
    step(); #1;
    n_cmp++; if (rq_v_a !== 1'b0) begin n_bad++; $display("FAIL reset_req_valid got %b want 0", rq_v_a); end
    n_cmp++; if (iv_a !== 2'b00) begin n_bad++; $display("FAIL reset_inst_valid got %b want 00", iv_a); end
    n_cmp++; if (rq_v_b !== 1'b0) begin n_bad++; $display("FAIL reset_req_valid_b got %b want 0", rq_v_b); end
    do_reset(); #1;
    n_cmp++; if (rq_v_a !== 1'b1 || rq_addr_a !== 32'h0) begin
      n_bad++; $display("FAIL first_req got v=%b a=%h want v=1 a=0", rq_v_a, rq_addr_a); end
    n_cmp++; if (rq_v_b !== 1'b1 || rq_addr_b !== RPC_B) begin
      n_bad++; $display("FAIL first_req_b got v=%b a=%h want v=1 a=%h", rq_v_b, rq_addr_b, RPC_B); end
    n_cmp++; if (iv_b !== 4'b0000) begin n_bad++; $display("FAIL reset_inst_valid_b got %b want 0000", iv_b); end
  endtask

  task automatic test_stream();
    logic        erv [5];
    logic [31:0] era [5];
    logic [1:0]  eiv [5];
    logic [31:0] epc [5];
    erv = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    era = '{32'h0, 32'h0, 32'h8, 32'h0, 32'h10};
    eiv = '{2'b00, 2'b00, 2'b11, 2'b00, 2'b11};
    epc = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h8};
    do_reset();
    cp_a = 2'b11;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++; if (rq_v_a !== erv[c] || (erv[c] && rq_addr_a !== era[c])) begin
        n_bad++; $display("FAIL stream_req c%0d got v=%b a=%h want v=%b a=%h", c, rq_v_a, rq_addr_a, erv[c], era[c]); end
      n_cmp++; if (iv_a !== eiv[c]) begin
        n_bad++; $display("FAIL stream_valid c%0d got %b want %b", c, iv_a, eiv[c]); end
      if (eiv[c] == 2'b11) begin
        n_cmp++; if (pc_a[0] !== epc[c] || pc_a[1] !== epc[c] + 32'h4 ||
                     inst_a[0] !== mk(epc[c]) || inst_a[1] !== mk(epc[c] + 32'h4)) begin
          n_bad++; $display("FAIL stream_lanes c%0d got pc %h/%h want %h/%h", c, pc_a[0], pc_a[1], epc[c], epc[c] + 32'h4); end
      end
      step();
    end
  endtask

  task automatic test_fill();
    do_reset();
    cp_a = 2'b00;
    for (int c = 0; c < 8; c++) step();
    #1;
    n_cmp++; if (rq_v_a !== 1'b0) begin n_bad++; $display("FAIL full_req got %b want 0", rq_v_a); end
    n_cmp++; if (iv_a !== 2'b11 || pc_a[0] !== 32'h0) begin
      n_bad++; $display("FAIL full_head got v=%b pc=%h want 11 pc=0", iv_a, pc_a[0]); end
    for (int c = 0; c < 3; c++) begin
      step(); #1;
      n_cmp++; if (rq_v_a !== 1'b0) begin n_bad++; $display("FAIL full_hold c%0d got %b want 0", c, rq_v_a); end
    end
    step(); cp_a = 2'b11; #1;
    n_cmp++; if (rq_v_a !== 1'b0) begin n_bad++; $display("FAIL full_deq_cycle got %b want 0", rq_v_a); end
    step(); cp_a = 2'b00; #1;
    n_cmp++; if (rq_v_a !== 1'b1 || rq_addr_a !== 32'h20) begin
      n_bad++; $display("FAIL refill_req got v=%b a=%h want v=1 a=20", rq_v_a, rq_addr_a); end
    n_cmp++; if (pc_a[0] !== 32'h8) begin n_bad++; $display("FAIL refill_head got %h want 8", pc_a[0]); end
  endtask

  task automatic test_single_lane();
    logic [31:0] exp;
    do_reset();
    cp_a = 2'b01;
    step(); step();
    exp = 32'h0;
    for (int c = 0; c < 24; c++) begin
      #1;
      n_cmp++; if (iv_a[0] !== 1'b1 || pc_a[0] !== exp || inst_a[0] !== mk(exp)) begin
        n_bad++; $display("FAIL single_lane c%0d got v=%b pc=%h want v=1 pc=%h", c, iv_a[0], pc_a[0], exp); end
      exp = exp + 32'h4;
      step();
    end
  endtask

  task automatic test_stale();
    do_reset();
    cp_a = 2'b00; lat_a = 3;
    #1;
    n_cmp++; if (rq_v_a !== 1'b1 || rq_addr_a !== 32'h0) begin
      n_bad++; $display("FAIL stale_first_req got v=%b a=%h want v=1 a=0", rq_v_a, rq_addr_a); end
    step(); redir_a = 1'b1; rpc_a = 32'h100; #1;
    n_cmp++; if (rq_v_a !== 1'b0) begin n_bad++; $display("FAIL stale_redir_req got %b want 0", rq_v_a); end
    step(); redir_a = 1'b0; #1;
    n_cmp++; if (rq_v_a !== 1'b0 || iv_a !== 2'b00) begin
      n_bad++; $display("FAIL stale_wait got v=%b iv=%b want 0/00", rq_v_a, iv_a); end
    step(); lat_a = 1; #1;
    n_cmp++; if (rq_v_a !== 1'b0) begin n_bad++; $display("FAIL stale_resp_cycle got %b want 0", rq_v_a); end
    step(); #1;
    n_cmp++; if (rq_v_a !== 1'b1 || rq_addr_a !== 32'h100) begin
      n_bad++; $display("FAIL stale_new_req got v=%b a=%h want v=1 a=100", rq_v_a, rq_addr_a); end
    n_cmp++; if (iv_a !== 2'b00) begin n_bad++; $display("FAIL stale_discard got %b want 00", iv_a); end
    step(); #1;
    n_cmp++; if (iv_a !== 2'b00) begin n_bad++; $display("FAIL stale_discard2 got %b want 00", iv_a); end
    step(); #1;
    n_cmp++; if (iv_a !== 2'b11 || pc_a[0] !== 32'h100 || pc_a[1] !== 32'h104 || inst_a[0] !== mk(32'h100)) begin
      n_bad++; $display("FAIL stale_target got v=%b pc=%h/%h want 11 100/104", iv_a, pc_a[0], pc_a[1]); end
  endtask

  task automatic test_redirect_resp();
    do_reset();
    cp_a = 2'b00; lat_a = 1;
    step(); step(); #1;
    n_cmp++; if (iv_a !== 2'b11 || rq_v_a !== 1'b1 || rq_addr_a !== 32'h8) begin
      n_bad++; $display("FAIL rr_pre got iv=%b v=%b a=%h want 11/1/8", iv_a, rq_v_a, rq_addr_a); end
    step(); redir_a = 1'b1; rpc_a = 32'h203; cp_a = 2'b11; #1;
    n_cmp++; if (rq_v_a !== 1'b0) begin n_bad++; $display("FAIL rr_redir_req got %b want 0", rq_v_a); end
    step(); redir_a = 1'b0; cp_a = 2'b00; #1;
    n_cmp++; if (iv_a !== 2'b00) begin n_bad++; $display("FAIL rr_flush got %b want 00", iv_a); end
    n_cmp++; if (rq_v_a !== 1'b1 || rq_addr_a !== 32'h200) begin
      n_bad++; $display("FAIL rr_target_req got v=%b a=%h want v=1 a=200", rq_v_a, rq_addr_a); end
    step(); step(); #1;
    n_cmp++; if (iv_a !== 2'b11 || pc_a[0] !== 32'h200 || inst_a[1] !== mk(32'h204)) begin
      n_bad++; $display("FAIL rr_target_data got v=%b pc=%h want 11 pc=200", iv_a, pc_a[0]); end
    n_cmp++; if (rq_v_a !== 1'b1 || rq_addr_a !== 32'h208) begin
      n_bad++; $display("FAIL rr_next_req got v=%b a=%h want v=1 a=208", rq_v_a, rq_addr_a); end
    redir_a = 1'b1; rpc_a = 32'h300; #1;
    n_cmp++; if (rq_v_a !== 1'b0) begin n_bad++; $display("FAIL idle_redir_req got %b want 0", rq_v_a); end
    step(); redir_a = 1'b0; #1;
    n_cmp++; if (iv_a !== 2'b00 || rq_v_a !== 1'b1 || rq_addr_a !== 32'h300) begin
      n_bad++; $display("FAIL idle_redir_after got iv=%b v=%b a=%h want 00/1/300", iv_a, rq_v_a, rq_addr_a); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    lat_a = 3;
    step(); reset = 1'b0; #1;
    n_cmp++; if (rq_v_a !== 1'b0) begin n_bad++; $display("FAIL midreset_req got %b want 0", rq_v_a); end
    step(); reset = 1'b1; #1;
    n_cmp++; if (rq_v_a !== 1'b1 || rq_addr_a !== 32'h0 || iv_a !== 2'b00) begin
      n_bad++; $display("FAIL midreset_after got v=%b a=%h iv=%b want 1/0/00", rq_v_a, rq_addr_a, iv_a); end
    lat_a = 1;
  endtask

  task automatic test_sweep();
    logic [31:0] exp;
    int n, retired;
    do_reset();
    exp = RPC_B; retired = 0;
    for (int c = 0; c < 800; c++) begin
      cp_b = WB'($urandom);
      rq_rdy_b = 1'($urandom_range(0, 1));
      lat_b = $urandom_range(1, 4);
      #1;
      n_cmp++; if ((iv_b & (iv_b + 4'b0001)) !== 4'b0000) begin
        n_bad++; $display("FAIL sweep_valid_shape c%0d got %b want contiguous", c, iv_b); end
      n = 0;
      for (int i = 0; i < WB; i++) begin
        if (cp_b[i] && iv_b[i]) n++;
        else break;
      end
      for (int i = 0; i < n; i++) begin
        n_cmp++; if (pc_b[i] !== exp || inst_b[i] !== mk(exp)) begin
          n_bad++; $display("FAIL sweep_order c%0d lane%0d got pc=%h inst=%h want pc=%h inst=%h",
                            c, i, pc_b[i], inst_b[i], exp, mk(exp)); end
        exp = exp + 32'h4;
      end
      retired += n;
      step();
    end
    n_cmp++; if (retired < 200) begin
      n_bad++; $display("FAIL sweep_progress got %0d retired want >= 200", retired); end
    rq_rdy_b = 1'b0; cp_b = '0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fill();
    test_single_lane();
    test_stale();
    test_redirect_resp();
    test_reset_mid();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised N-wide instruction fetch front end: it owns the fetch PC, issues aligned group requests to instruction memory, and buffers returned instructions in a circular queue. Up to WIDTH oldest entries are presented per cycle to decode. It sits between instruction memory and the decode stage. Over the plain dual-issue PC stepper it adds:
- arbitrary lane count;
- decoupling buffer with a memory handshake;
- a branch redirect that flushes the queue and kills in-flight fetches.

## Interface

Parameters:
- WIDTH, 2, lanes fetched per request and presented per cycle; ≥1.
- DEPTH, 8, queue entries; power of two, ≥ 2*WIDTH.
- RESET_PC, 32'h0000_0000, fetch PC after reset.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; all state cleared while low.
- redirect_valid  in  1  branch established; flush and refetch.
- redirect_pc  in  32  redirect target; bits [1:0] ignored (treated as 0).
- can_proceed  in  WIDTH  per-lane accept from decode; only the leading-ones prefix is honoured.
- imem_req_valid  out  1  request for WIDTH words starting at imem_req_addr.
- imem_req_addr  out  32  equals fetch PC.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_resp_valid  in  1  response data valid; in order, at most one outstanding.
- imem_resp_data  in  WIDTH*32  word k at bits [32k+31:32k] = instruction at addr+4k.
- inst_valid  out  WIDTH  lane i holds a valid queue entry.
- inst  out  WIDTH x 32  instruction of lane i (queue head + i).
- pc  out  WIDTH x 32  PC of lane i.

## Operation

- Queue entry holds {pc, inst}. Head pointer, tail pointer and count are $clog2(DEPTH)+1 bits; indices wrap modulo DEPTH.
- Lane i shows entry head+i; inst_valid[i] = (count > i) and not in the cycle after reset.
- Dequeue count n = number of leading lanes with can_proceed[i] && inst_valid[i], stopping at the first zero. Example: can_proceed=2'b10 dequeues 0.
- FSM states:
  - IDLE: imem_req_valid = (DEPTH − count ≥ WIDTH) && !redirect_valid. On valid && ready → WAIT.
  - WAIT: awaiting response. On imem_resp_valid: enqueue WIDTH entries (pc = fetch_pc + 4k), fetch_pc += 4*WIDTH, → IDLE.
  - STALE: awaiting a response that must be discarded. On imem_resp_valid: discard data, no enqueue → IDLE.
- Space check counts only the current count. The single-outstanding rule plus the check made at issue guarantees room at response time, since dequeue only frees entries.
- redirect_valid (any state):
  - count ← 0, head = tail, and this cycle's dequeue is ignored;
  - fetch_pc ← redirect_pc;
  - WAIT → STALE; STALE stays STALE; IDLE stays IDLE, with no request that cycle.
- Redirect coinciding with imem_resp_valid in WAIT: response discarded, → IDLE.
- Enqueue and dequeue in the same cycle are both applied: count += WIDTH − n.
- imem_resp_valid in IDLE is ignored (protocol violation; the bench asserts it never occurs).
- fetch_pc arithmetic is 32-bit and wraps at 2^32 silently.

## Timing

- Reset values: fetch_pc = RESET_PC, state IDLE, count 0, inst_valid all 0, imem_req_valid 0 while reset low.
- First request is issued in the first cycle after reset deasserts.
- Response data is visible on inst/pc the cycle after imem_resp_valid. With zero-wait memory (response the cycle after the handshake), request-to-decode latency is 2 cycles.
- Sustained throughput with 1-cycle memory is WIDTH instructions per 2 cycles (one outstanding request).
- Redirect takes effect at the next edge: outputs invalid next cycle, new request issued next cycle at redirect_pc.
- Reset asserted mid-request: state returns to IDLE immediately. Any later response is ignored as an IDLE violation; the memory model is reset alongside.

## Structure

- Package fetch_pkg:
  - inst_t (logic [31:0]);
  - fetch_entry_t struct {pc, inst};
  - state enum {IDLE, WAIT, STALE};
  - localparam INST_BYTES = 4.
- Sub-module fetch_fifo: DEPTH-entry circular buffer with WIDTH-wide enqueue, variable 0..WIDTH dequeue, flush input, count output and WIDTH read ports.
- fetch_queue holds the FSM, fetch_pc register and dequeue-prefix logic.

## Test plan

- Reset, then 1-cycle memory, can_proceed all 1 → requests at 0x0, 0x8, 0x10; lanes show pc 0x0/0x4, then 0x8/0xC; no gaps beyond the 2-cycle cadence.
- can_proceed=0 held, WIDTH=2, DEPTH=8 → four responses fill the queue (count 8). imem_req_valid drops to 0 and stays 0 until one dequeue of 2.
- can_proceed=2'b01 steady → exactly one instruction retired per cycle; PCs strictly sequential across the wrap of head index 7→0.
- redirect_valid with redirect_pc=0x100 while in WAIT; memory returns old data 3 cycles later → old data never appears; next request addr 0x100 issued only after the stale response.
- Redirect in the same cycle as imem_resp_valid → no enqueue, inst_valid 0 next cycle, request at target next cycle.
- WIDTH=4, DEPTH=16 parameter sweep with random can_proceed/ready/latency → scoreboard checks in-order sequential PCs and no loss or duplication.
